// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
//   clock, least significant digit first, with a registered borrow between
//   digits. Also reports the unsigned borrow-out and the signed overflow.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready operand handshake (a, b, bin); in_ready high only in IDLE
//   a, b, bin           minuend, subtrahend, borrow-in
//   out_valid/out_ready result handshake; out_valid high only in HOLD
//   diff, bout, ovf     difference, unsigned borrow-out, signed overflow
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds valid (and its data)
// until that edge; the consumer may raise or drop ready freely. Results stay on
// diff/bout/ovf after the transfer until the next operation overwrites them.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic             a_msb;
  logic             b_msb;

  logic [DIGIT:0]   step_sum;
  logic [DIGIT-1:0] step_diff;
  logic             step_brw;
  logic [WIDTH-1:0] diff_shifted;
  logic             last_step;

  // One digit of the subtraction. The extra top bit of the (DIGIT+1)-bit
  // result is set exactly when the digit result went negative, i.e. the borrow.
  assign step_sum  = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, brw};
  assign step_diff = step_sum[DIGIT-1:0];
  assign step_brw  = step_sum[DIGIT];
  assign last_step = (cnt == LAST);

  // New digits enter at the MSB end so that after STEPS shifts the first
  // (least significant) digit has arrived at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign diff_shifted = step_diff;
    end else begin : g_multi
      assign diff_shifted = {step_diff, diff[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_step) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_sh  <= a;
        b_sh  <= b;
        brw   <= bin;
        cnt   <= '0;
        // Operand sign bits are kept aside: the shift registers lose them.
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      brw  <= step_brw;
      cnt  <= cnt + CW'(1);
      diff <= diff_shifted;
      if (last_step) begin
        bout <= step_brw;
        // The last digit carries the result sign bit in its top position.
        ovf  <= (a_msb ^ b_msb) & (step_diff[DIGIT-1] ^ a_msb);
      end
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor: computes A - B - bin over WIDTH bits, processing DIGIT bits per clock with a registered borrow chain.
- Next generation of the team's single-bit half/full subtractor cells. Intended for area-constrained datapaths where a full-width ripple subtractor is not wanted.
- Operands enter and results leave through valid/ready handshakes.
- Produces the difference, the unsigned borrow-out and a signed-overflow flag.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits subtracted per clock cycle (1 = fully bit-serial; DIGIT = WIDTH = single cycle).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result is valid (high only in HOLD).
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  unsigned borrow-out (1 when a < b + bin).
- ovf  output  1  two's-complement overflow of the subtraction.

Behaviour:
- STEPS = WIDTH/DIGIT. Internal step counter width is clog2(STEPS)+1.
- Reset, asynchronous and immediate:
  - state = IDLE, in_ready = 1, out_valid = 0, diff = 0, bout = 0, ovf = 0.
  - counter, operand shift registers and borrow register cleared.
  - Reset asserted mid-operation abandons the operation; no partial result is ever presented.
- FSM has three states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: latch a, b; load borrow register with bin; counter = 0; go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle, subtract the low DIGIT bits of the shifted operands plus the borrow register.
  - Shift the DIGIT result bits into diff from the MSB side (LSB digit processed first).
  - Update the borrow register; counter += 1.
  - When counter reaches STEPS-1 at an edge, perform the final digit and go to HOLD.
- Latency: out_valid rises exactly STEPS cycles after the accepting edge. For WIDTH=8, DIGIT=1 that is 8 cycles; for DIGIT=8 it is 1 cycle.
- HOLD:
  - out_valid = 1; diff, bout and ovf are stable and must not change while out_valid is high.
  - bout = final borrow register value.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), computed from the latched operands.
  - On out_valid & out_ready at an edge: go to IDLE.
  - Results remain on the outputs until the next operation overwrites them; out_valid is 0 in IDLE.
- Back-pressure: out_ready low holds HOLD indefinitely. No new operand is accepted until the result is taken (no overlap, throughput of 1 per STEPS+2 cycles minimum).
- in_valid while busy is ignored; the operands are not queued. A producer must hold in_valid until in_ready.
- out_ready while not in HOLD has no effect.
- bin = 1 with a = b yields diff = all ones, bout = 1.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 -> out_valid exactly 8 cycles after accept; diff=0x02, bout=0, ovf=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, diff constant, in_ready stays 0. A second in_valid pulse during this window is not consumed.
- Reset mid-RUN: assert rst at step 3 of a=0xAA, b=0x55 -> outputs return to reset values immediately. After release, a new operation a=0x10, b=0x01 -> diff=0x0F.
- Rebuild with DIGIT=4 and DIGIT=8: exhaustive a, b in 0..255 with bin in {0,1} -> diff, bout, ovf match the reference model. Latency is 2 and 1 cycles respectively.
